// File: rtl/montgomery_stream_if.sv
// Stream wrapper for the montgomery core: gathers A/B/M from a word stream, runs the core, streams the result out.
// Optional MONT_IF_REUSE_M_EN adds reuse_m to skip reloading M and keep the previous modulus.
module montgomery_stream_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 512
) (
    input  logic              clk,
    input  logic              reset,
`ifdef MONT_IF_REUSE_M_EN
    input  logic              reuse_m,
`endif
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OP_W-1:0]   mont_a,
    output logic [OP_W-1:0]   mont_b,
    output logic [OP_W-1:0]   mont_m,
    output logic              mont_start,
    input  logic [OP_W-1:0]   mont_result,
    input  logic              mont_done,
    output logic              busy
);
    localparam int WORDS = OP_W / DATA_W;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_M,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [OP_W-1:0]   shift_q, shift_d;
    logic              last_word;
    logic              loading;
    logic              skip_m;

    assign last_word = (wcnt_q == CW'(WORDS - 1));
    assign loading   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_LOAD_M);

`ifdef MONT_IF_REUSE_M_EN
    assign skip_m = reuse_m;
`else
    assign skip_m = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        shift_d = shift_q;
        // Operand buses only move in LOAD states, so they stay frozen while the core runs.
        case (state_q)
            S_LOAD_A: begin
                if (s_valid) begin
                    a_d[wcnt_q*DATA_W +: DATA_W] = s_data;
                    wcnt_d = last_word ? '0 : wcnt_q + 1'b1;
                    if (last_word) state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (s_valid) begin
                    b_d[wcnt_q*DATA_W +: DATA_W] = s_data;
                    wcnt_d = last_word ? '0 : wcnt_q + 1'b1;
                    if (last_word) state_d = skip_m ? S_START : S_LOAD_M;
                end
            end
            S_LOAD_M: begin
                if (s_valid) begin
                    m_d[wcnt_q*DATA_W +: DATA_W] = s_data;
                    wcnt_d = last_word ? '0 : wcnt_q + 1'b1;
                    if (last_word) state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (mont_done) begin
                    shift_d = mont_result;
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (m_ready) begin
                    shift_d = shift_q >> DATA_W;
                    wcnt_d  = last_word ? '0 : wcnt_q + 1'b1;
                    if (last_word) state_d = S_LOAD_A;
                end
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD_A;
            wcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            shift_q <= shift_d;
        end
    end

    assign s_ready    = loading;
    assign m_valid    = (state_q == S_UNLOAD);
    assign m_data     = shift_q[DATA_W-1:0];
    assign mont_a     = a_q;
    assign mont_b     = b_q;
    assign mont_m     = m_q;
    assign mont_start = (state_q == S_START);
    assign busy       = !((state_q == S_LOAD_A) && (wcnt_q == '0));

endmodule

// File: tb/tb_montgomery_stream_if.sv
// Directed bench for montgomery_stream_if with a montgomery stub (done N cycles after start, result = a^b^m).
module tb_montgomery_stream_if;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [511:0] mont_a, mont_b, mont_m;
    logic         mont_start;
    logic [511:0] mont_result = '0;
    logic         mont_done = 1'b0;
    logic         busy;
`ifdef MONT_IF_REUSE_M_EN
    logic         reuse_v = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int stub_n = 5;
    int scnt = 0;
    logic srun = 1'b0;

    logic [31:0] got [16];
    int n_got, stall_err, sready_err;

    montgomery_stream_if #(.DATA_W(32), .OP_W(512)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MONT_IF_REUSE_M_EN
        .reuse_m     (reuse_v),
`endif
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .mont_a      (mont_a),
        .mont_b      (mont_b),
        .mont_m      (mont_m),
        .mont_start  (mont_start),
        .mont_result (mont_result),
        .mont_done   (mont_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mont_start) start_cnt++;

    // Stub core: independent of the wrapper reset so a late done can be observed.
    always @(posedge clk) begin
        mont_done <= 1'b0;
        if (mont_start) begin
            if (stub_n <= 1) begin
                mont_done   <= 1'b1;
                mont_result <= mont_a ^ mont_b ^ mont_m;
                srun        <= 1'b0;
            end else begin
                scnt <= stub_n - 1;
                srun <= 1'b1;
            end
        end else if (srun) begin
            if (scnt <= 1) begin
                mont_done   <= 1'b1;
                mont_result <= mont_a ^ mont_b ^ mont_m;
                srun        <= 1'b0;
            end else begin
                scnt <= scnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams nwords words: operand o word k = base[o] + k. Leaves s_valid low afterwards.
    task automatic load_op(input int nwords, input bit rnd,
                           input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bm);
        int i;
        int cyc;
        logic [31:0] base;
        i = 0;
        cyc = 0;
        while (i < nwords && cyc < 2000) begin
            base = (i < 16) ? ba : (i < 32) ? bb : bm;
            s_data  = base + 32'(i % 16);
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (s_valid) i++;
            cyc++;
        end
        s_valid = 1'b0;
    endtask

    // Drains up to 16 result words; mode 1 toggles m_ready 1,0,0,...
    task automatic unload(input int mode);
        int cyc;
        logic [31:0] prev;
        logic stalled;
        cyc = 0;
        prev = '0;
        stalled = 1'b0;
        n_got = 0;
        stall_err = 0;
        sready_err = 0;
        while (n_got < 16 && cyc < 300) begin
            m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (s_ready !== 1'b0) sready_err++;
            if (stalled && (m_valid !== 1'b1 || m_data !== prev)) stall_err++;
            if (m_valid && m_ready) begin
                got[n_got] = m_data;
                n_got++;
                stalled = 1'b0;
            end else begin
                stalled = m_valid;
                prev = m_data;
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
        total++; if (mont_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b exp=0", mont_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if ((mont_a | mont_b | mont_m) !== 512'h0) begin bad++; $display("FAIL reset_buses got=%h exp=0", mont_a | mont_b | mont_m); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic(input bit rnd, input int mode, input string nm);
        logic [511:0] ea, eb, em;
        int s0;
        for (int k = 0; k < 16; k++) begin
            ea[32*k +: 32] = 32'(k);
            eb[32*k +: 32] = 32'h100 + 32'(k);
            em[32*k +: 32] = 32'h200 + 32'(k);
        end
        stub_n = 5;
        s0 = start_cnt;
        s_data = 32'h0; s_valid = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_mid got=%0b exp=1", nm, busy); end
        // first word already accepted above when rnd==0; restart cleanly via reset
        reset = 1'b1; s_valid = 1'b0; tick(); reset = 1'b0;
        load_op(48, rnd, 32'h0, 32'h100, 32'h200);
        total++; if (mont_start !== 1'b1) begin bad++; $display("FAIL %s start_pos got=%0b exp=1", nm, mont_start); end
        total++; if (start_cnt !== s0) begin bad++; $display("FAIL %s start_early got=%0d exp=%0d", nm, start_cnt, s0); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL %s sready_start got=%0b exp=0", nm, s_ready); end
        total++; if (mont_a[31:0] !== 32'h0 || mont_a[511:480] !== 32'hF) begin bad++; $display("FAIL %s a_words got=%h/%h exp=0/f", nm, mont_a[31:0], mont_a[511:480]); end
        total++; if (mont_m[511:480] !== 32'h20F) begin bad++; $display("FAIL %s m_top got=%h exp=20f", nm, mont_m[511:480]); end
        total++; if (mont_a !== ea || mont_b !== eb || mont_m !== em) begin bad++; $display("FAIL %s buses got_b_low=%h exp=100", nm, mont_b[31:0]); end
        tick();
        total++; if (mont_start !== 1'b0 || start_cnt !== s0 + 1) begin bad++; $display("FAIL %s start_width got=%0b cnt=%0d exp=0 cnt=%0d", nm, mont_start, start_cnt, s0 + 1); end
        unload(mode);
        total++; if (n_got !== 16) begin bad++; $display("FAIL %s word_count got=%0d exp=16", nm, n_got); end
        for (int k = 0; k < 16; k++) begin
            total++; if (got[k] !== 32'h300 + 32'(k)) begin bad++; $display("FAIL %s word%0d got=%h exp=%h", nm, k, got[k], 32'h300 + 32'(k)); end
        end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL %s stall_hold got=%0d exp=0", nm, stall_err); end
        total++; if (sready_err !== 0) begin bad++; $display("FAIL %s sready_busy got=%0d exp=0", nm, sready_err); end
        total++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL %s idle_after got=%0b%0b%0b exp=010", nm, m_valid, s_ready, busy); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL %s no_dup got=%0b exp=0", nm, m_valid); end
    endtask

    task automatic test_reset_in_wait();
        int extra;
        stub_n = 20;
        load_op(48, 1'b0, 32'h0, 32'h100, 32'h200);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wait_reset got=%0b%0b%0b exp=100", s_ready, m_valid, busy); end
        total++; if (mont_a !== 512'h0) begin bad++; $display("FAIL wait_reset_bus got=%h exp=0", mont_a[31:0]); end
        extra = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        m_ready = 1'b0;
        total++; if (extra !== 0) begin bad++; $display("FAIL stale_done got=%0d exp=0", extra); end
    endtask

    task automatic test_fast_done();
        int cyc;
        stub_n = 1;
        load_op(48, 1'b0, 32'h0, 32'h100, 32'h200);
        cyc = 0;
        while (mont_done !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        total++; if (mont_done !== 1'b1) begin bad++; $display("FAIL fast_done_seen got=%0b exp=1", mont_done); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL fast_pre_valid got=%0b exp=0", m_valid); end
        tick();
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL fast_valid got=%0b exp=1", m_valid); end
        unload(0);
        total++; if (n_got !== 16 || got[0] !== 32'h300 || got[15] !== 32'h30F) begin bad++; $display("FAIL fast_result got=%0d %h %h exp=16 300 30f", n_got, got[0], got[15]); end
    endtask

`ifdef MONT_IF_REUSE_M_EN
    task automatic test_reuse_m();
        logic [511:0] m_prev;
        stub_n = 5;
        reuse_v = 1'b0;
        load_op(48, 1'b0, 32'h0, 32'h100, 32'h200);
        unload(0);
        m_prev = mont_m;
        reuse_v = 1'b1;
        load_op(32, 1'b0, 32'h400, 32'h600, 32'h0);
        total++; if (mont_start !== 1'b1) begin bad++; $display("FAIL reuse_start got=%0b exp=1", mont_start); end
        total++; if (mont_m !== m_prev || mont_m[511:480] !== 32'h20F) begin bad++; $display("FAIL reuse_m_bus got=%h exp=20f", mont_m[511:480]); end
        unload(0);
        reuse_v = 1'b0;
        for (int k = 0; k < 16; k++) begin
            total++; if (got[k] !== 32'(k)) begin bad++; $display("FAIL reuse_word%0d got=%h exp=%h", k, got[k], 32'(k)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0, 0, "plain");
        test_basic(1'b0, 1, "backpressure");
        test_basic(1'b1, 0, "gappy");
        test_reset_in_wait();
        test_fast_done();
`ifdef MONT_IF_REUSE_M_EN
        test_reuse_m();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
